ysyx_22050710_axil_lsu_master: RTL and testbench

AXI4-Lite initiator that converts the load/store unit's simple request/response interface into AXI4-Lite read or write transactions. It sits inside the CPU between the LSU and the shared AXI4-Lite bus that reaches the SRAM wrapper. It has exactly one transaction outstanding at a time, and all bus outputs are registered.

---
 rtl/ysyx_22050710_axil_lsu_master_if.sv | 42 ++++
 rtl/ysyx_22050710_axil_lsu_master.sv | 116 +++++++++++
 tb/tb_ysyx_22050710_axil_lsu_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050710_axil_lsu_master_if.sv
// ysyx_22050710_axil_lsu_master_if: LSU request/response plus AXI4-Lite bus bundle
// master: the LSU-to-AXI bridge view; slave: the LSU + bus responder view (the bench)
interface ysyx_22050710_axil_lsu_master_if #(
  parameter int ADDR_WD = 64,
  parameter int DATA_WD = 64,
  parameter int STRB_WD = DATA_WD / 8
);
  logic               req_valid, req_ready, req_wen;
  logic [ADDR_WD-1:0] req_addr;
  logic [DATA_WD-1:0] req_wdata;
  logic [STRB_WD-1:0] req_wmask;
  logic               rsp_valid, rsp_err;
  logic [DATA_WD-1:0] rsp_rdata;
  logic               awvalid, awready;
  logic [ADDR_WD-1:0] awaddr;
  logic [2:0]         awprot;
  logic               wvalid, wready;
  logic [DATA_WD-1:0] wdata;
  logic [STRB_WD-1:0] wstrb;
  logic               bvalid, bready;
  logic [1:0]         bresp;
  logic               arvalid, arready;
  logic [ADDR_WD-1:0] araddr;
  logic [2:0]         arprot;
  logic               rvalid, rready;
  logic [DATA_WD-1:0] rdata;
  logic [1:0]         rresp;
  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ysyx_22050710_axil_lsu_master.sv
// ysyx_22050710_axil_lsu_master: LSU request/response to AXI4-Lite initiator, one transaction outstanding
// i_clk/i_rst: clock and synchronous active-high reset; bus: request, response and AXI4-Lite channels
module ysyx_22050710_axil_lsu_master #(
  parameter int         ADDR_WD  = 64,
  parameter int         DATA_WD  = 64,
  parameter int         STRB_WD  = DATA_WD / 8,
  parameter logic [2:0] PROT_VAL = 3'b000
) (
  input logic                             i_clk,
  input logic                             i_rst,
  ysyx_22050710_axil_lsu_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;
  state_e             state_q, state_d;
  logic               arvalid_q, arvalid_d, rready_q, rready_d;
  logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic               rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic [DATA_WD-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_WD-1:0] wstrb_q, wstrb_d;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wstrb_q     <= wstrb_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    rsp_valid_d = 1'b0;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    wstrb_d     = wstrb_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d    = bus.req_addr;
        wdata_d   = bus.req_wdata;
        wstrb_d   = bus.req_wmask;
        state_d   = bus.req_wen ? WR_REQ : RD_ADDR;
        arvalid_d = !bus.req_wen;
        awvalid_d = bus.req_wen;
        wvalid_d  = bus.req_wen;
      end
      RD_ADDR: if (bus.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_DATA;
      end
      RD_DATA: if (bus.rvalid) begin
        rdata_d     = bus.rdata;
        err_d       = |bus.rresp;
        rsp_valid_d = 1'b1;
        rready_d    = 1'b0;
        state_d     = IDLE;
      end
      WR_REQ: begin
        // AW and W retire independently; move on once neither is still pending
        awvalid_d = awvalid_q & !bus.awready;
        wvalid_d  = wvalid_q & !bus.wready;
        bready_d  = !awvalid_d && !wvalid_d;
        state_d   = bready_d ? WR_RESP : WR_REQ;
      end
      WR_RESP: if (bus.bvalid) begin
        err_d       = |bus.bresp;
        rsp_valid_d = 1'b1;
        bready_d    = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.awvalid   = awvalid_q;
  assign bus.awaddr    = addr_q;
  assign bus.awprot    = PROT_VAL;
  assign bus.wvalid    = wvalid_q;
  assign bus.wdata     = wdata_q;
  assign bus.wstrb     = wstrb_q;
  assign bus.bready    = bready_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = addr_q;
  assign bus.arprot    = PROT_VAL;
  assign bus.rready    = rready_q;
endmodule

// File: tb/tb_ysyx_22050710_axil_lsu_master.sv
// tb_ysyx_22050710_axil_lsu_master: vector table plus corner sequences against a response scoreboard
module tb_ysyx_22050710_axil_lsu_master;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  ysyx_22050710_axil_lsu_master_if bus ();
  ysyx_22050710_axil_lsu_master dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  typedef struct {
    logic        wen;
    logic [63:0] addr, wdata;
    logic [7:0]  wmask;
    int          d1, d2, d3;
    logic [1:0]  resp;
    logic [63:0] rdata;
  } vec_t;
  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t        sb[$];
  vec_t        vecs[7];
  int          checks = 0, failures = 0;
  logic [63:0] last_rd = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected act=1 exp=0");
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk1("rsp_err", bus.rsp_err, e.err);
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk1("req_ready_idle", bus.req_ready, 1'b1);
  endtask
  task automatic run(input vec_t v);
    int m;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wen   = v.wen;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_wmask = v.wmask;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    bus.req_wmask = '1;
    chk1("req_ready_busy", bus.req_ready, 1'b0);
    if (v.wen) sb.push_back(rsp_t'{last_rd, |v.resp});
    else begin
      sb.push_back(rsp_t'{v.rdata, |v.resp});
      last_rd = v.rdata;
    end
    if (!v.wen) begin
      for (int c = 0; c <= v.d1; c++) begin
        chk1("arvalid", bus.arvalid, 1'b1);
        chk("araddr", bus.araddr, v.addr);
        chk("arprot", 64'(bus.arprot), 64'd0);
        chk1("rready_early", bus.rready, 1'b0);
        bus.arready = c == v.d1;
        bus.bvalid  = 1'b1;
        tick();
      end
      bus.arready = 1'b0;
      bus.bvalid  = 1'b0;
      chk1("arvalid_clr", bus.arvalid, 1'b0);
      for (int c = 0; c <= v.d3; c++) begin
        chk1("rready", bus.rready, 1'b1);
        bus.rvalid = c == v.d3;
        bus.rdata  = v.rdata;
        bus.rresp  = v.resp;
        tick();
      end
      bus.rvalid = 1'b0;
      chk1("rready_clr", bus.rready, 1'b0);
    end else begin
      m = v.d1 > v.d2 ? v.d1 : v.d2;
      for (int c = 0; c <= m; c++) begin
        chk1("awvalid", bus.awvalid, c <= v.d1);
        chk1("wvalid", bus.wvalid, c <= v.d2);
        chk1("bready_early", bus.bready, 1'b0);
        if (c <= v.d1) chk("awaddr", bus.awaddr, v.addr);
        if (c <= v.d2) chk("wdata", bus.wdata, v.wdata);
        if (c <= v.d2) chk("wstrb", 64'(bus.wstrb), 64'(v.wmask));
        bus.awready = c == v.d1;
        bus.wready  = c == v.d2;
        bus.rvalid  = 1'b1;
        tick();
      end
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.rvalid  = 1'b0;
      chk1("awvalid_clr", bus.awvalid, 1'b0);
      chk1("wvalid_clr", bus.wvalid, 1'b0);
      for (int c = 0; c <= v.d3; c++) begin
        chk1("bready", bus.bready, 1'b1);
        bus.bvalid = c == v.d3;
        bus.bresp  = v.resp;
        tick();
      end
      bus.bvalid = 1'b0;
      chk1("bready_clr", bus.bready, 1'b0);
    end
    chk1("rsp_valid", bus.rsp_valid, 1'b1);
    chk1("req_ready_rsp", bus.req_ready, 1'b1);
    tick();
    chk1("rsp_pulse", bus.rsp_valid, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = vec_t'{1'b0, 64'h8000_0010, 64'h0, 8'h00, 0, 0, 0, 2'b00, 64'h1122_3344_5566_7788};
    vecs[1] = vec_t'{1'b1, 64'h8000_0100, 64'hDEAD_BEEF, 8'h0F, 0, 2, 1, 2'b00, 64'h0};
    vecs[2] = vec_t'{1'b1, 64'h8000_0200, 64'hCAFE_F00D_1234_5678, 8'hF0, 3, 0, 0, 2'b00, 64'h0};
    vecs[3] = vec_t'{1'b1, 64'h8000_0300, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 1, 2, 2'b00, 64'h0};
    vecs[4] = vec_t'{1'b0, 64'h8000_0018, 64'h0, 8'h00, 2, 0, 1, 2'b10, 64'hA5A5_5A5A_0F0F_F0F0};
    vecs[5] = vec_t'{1'b1, 64'h8000_0400, 64'h5555_AAAA_5555_AAAA, 8'h3C, 0, 0, 0, 2'b11, 64'h0};
    vecs[6] = vec_t'{1'b0, 64'h8000_0020, 64'h0, 8'h00, 0, 0, 0, 2'b00, 64'h0F0E_0D0C_0B0A_0908};
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.awready   = 1'b0;
    bus.wready    = 1'b0;
    bus.bvalid    = 1'b0;
    bus.bresp     = 2'b00;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = 2'b00;
    repeat (2) tick();
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_arvalid", bus.arvalid, 1'b0);
    chk1("rst_awvalid", bus.awvalid, 1'b0);
    chk1("rst_wvalid", bus.wvalid, 1'b0);
    chk1("rst_bready", bus.bready, 1'b0);
    chk1("rst_rready", bus.rready, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_araddr", bus.araddr, 64'd0);
    chk("rst_wdata", bus.wdata, 64'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) run(vecs[i]);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 64'h8000_0800;
    tick();
    bus.req_valid = 1'b0;
    bus.arready   = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk1("mid_rready", bus.rready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("mid_arvalid", bus.arvalid, 1'b0);
    chk1("mid_rready_clr", bus.rready, 1'b0);
    chk1("mid_req_ready", bus.req_ready, 1'b1);
    chk1("mid_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_rsp_rdata", bus.rsp_rdata, 64'd0);
    last_rd = '0;
    repeat (3) tick();
    run(vecs[6]);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 64'h8000_0900;
    bus.req_wdata = 64'h0BAD_F00D_600D_CAFE;
    bus.req_wmask = 8'hFF;
    tick();
    sb.push_back(rsp_t'{last_rd, 1'b0});
    bus.req_wen   = 1'b0;
    bus.req_addr  = 64'h8000_0A00;
    bus.req_wdata = '0;
    chk("b2b_awaddr", bus.awaddr, 64'h8000_0900);
    chk("b2b_wdata", bus.wdata, 64'h0BAD_F00D_600D_CAFE);
    chk1("b2b_arvalid_idle", bus.arvalid, 1'b0);
    bus.awready = 1'b1;
    bus.wready  = 1'b1;
    tick();
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    chk1("b2b_bready", bus.bready, 1'b1);
    bus.bvalid = 1'b1;
    bus.bresp  = 2'b00;
    tick();
    bus.bvalid = 1'b0;
    chk1("b2b_wr_rsp", bus.rsp_valid, 1'b1);
    chk1("b2b_ready", bus.req_ready, 1'b1);
    sb.push_back(rsp_t'{64'h7766_5544_3322_1100, 1'b0});
    last_rd = 64'h7766_5544_3322_1100;
    tick();
    bus.req_valid = 1'b0;
    chk1("b2b_busy", bus.req_ready, 1'b0);
    chk1("b2b_arvalid", bus.arvalid, 1'b1);
    chk("b2b_araddr", bus.araddr, 64'h8000_0A00);
    chk1("b2b_no_dup", bus.rsp_valid, 1'b0);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 64'h7766_5544_3322_1100;
    bus.rresp   = 2'b00;
    tick();
    bus.rvalid = 1'b0;
    chk1("b2b_rd_rsp", bus.rsp_valid, 1'b1);
    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
